// File: rtl/phys_reg_free_list_pkg.sv
// Shared types for the physical register free list: sizing constants,
// physical register tag, FIFO pointer and free-count types.
package phys_reg_free_list_pkg;

  localparam int unsigned NUM_PREGS       = 64;
  localparam int unsigned NUM_AREGS       = 32;
  localparam int unsigned WIDTH           = 2;
  localparam int unsigned PREG_W          = $clog2(NUM_PREGS);
  localparam int unsigned COUNT_W         = PREG_W + 1;
  localparam int unsigned FREE_LIST_DEPTH = NUM_PREGS;
  localparam int unsigned INIT_FREE       = NUM_PREGS - NUM_AREGS;

  typedef logic [PREG_W-1:0]  p_reg_t;
  typedef logic [PREG_W-1:0]  ptr_t;
  typedef logic [COUNT_W-1:0] free_count_t;

endpackage

// File: rtl/phys_reg_free_list_popcount2.sv
// Two-lane population count, used for both request and accepted-free lanes.
module phys_reg_free_list_popcount2 (
  input  logic [1:0] bits,
  output logic [1:0] count_c
);

  assign count_c = {bits[1] & bits[0], bits[1] ^ bits[0]};

endmodule

// File: rtl/phys_reg_free_list.sv
// Circular FIFO of free physical registers: two-lane all-or-nothing allocate
// for rename, two-lane release from retire, sticky overflow error.
module phys_reg_free_list
  import phys_reg_free_list_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_alloc_req  [0:WIDTH-1],
  output p_reg_t      o_alloc_preg [0:WIDTH-1],
  output logic        o_alloc_grant,
  input  logic        i_free_en    [0:WIDTH-1],
  input  p_reg_t      i_free_preg  [0:WIDTH-1],
  output free_count_t o_free_count,
  output logic        o_empty,
  output logic        o_err
);

  p_reg_t      entry [FREE_LIST_DEPTH];
  ptr_t        head;
  ptr_t        tail;
  free_count_t count;
  logic        empty;
  logic        err;

  logic [1:0]  nreq_c;
  logic [1:0]  pops_c;
  logic [1:0]  nfree_c;
  logic        grant_c;
  logic        valid0_c;
  logic        valid1_c;
  logic        acc0_c;
  logic        acc1_c;
  logic        drop_c;
  free_count_t base_c;
  free_count_t room_c;
  free_count_t count_next_c;

  phys_reg_free_list_popcount2 u_req_count (
    .bits    ({i_alloc_req[1], i_alloc_req[0]}),
    .count_c (nreq_c)
  );

  phys_reg_free_list_popcount2 u_free_count (
    .bits    ({acc1_c, acc0_c}),
    .count_c (nfree_c)
  );

  // Offer and grant come from the registered count only; same-cycle frees
  // never feed the current offer.
  always_comb begin
    grant_c         = !i_rst && (count >= free_count_t'(nreq_c));
    pops_c          = grant_c ? nreq_c : 2'd0;
    o_alloc_preg[0] = entry[head];
    o_alloc_preg[1] = (i_alloc_req[1] && !i_alloc_req[0]) ? entry[head]
                                                          : entry[head + ptr_t'(1)];
  end

  // Frees of p0 are ignored; on overflow the highest lane is dropped first.
  always_comb begin
    valid0_c     = i_free_en[0] && (i_free_preg[0] != '0);
    valid1_c     = i_free_en[1] && (i_free_preg[1] != '0);
    base_c       = count - free_count_t'(pops_c);
    room_c       = free_count_t'(FREE_LIST_DEPTH - 1) - base_c;
    acc0_c       = valid0_c && (room_c != '0);
    acc1_c       = valid1_c && (room_c > free_count_t'(acc0_c));
    drop_c       = (valid0_c && !acc0_c) || (valid1_c && !acc1_c);
    count_next_c = base_c + free_count_t'(nfree_c);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned k = 0; k < INIT_FREE; k++) begin
        entry[ptr_t'(k)] <= p_reg_t'(NUM_AREGS + k);
      end
      head  <= '0;
      tail  <= ptr_t'(INIT_FREE);
      count <= free_count_t'(INIT_FREE);
      empty <= 1'b0;
      err   <= 1'b0;
    end else begin
      if (acc0_c) entry[tail] <= i_free_preg[0];
      if (acc1_c) entry[tail + ptr_t'(acc0_c)] <= i_free_preg[1];
      head  <= head + ptr_t'(pops_c);
      tail  <= tail + ptr_t'(nfree_c);
      count <= count_next_c;
      empty <= (count_next_c == '0);
      err   <= err | drop_c;
    end
  end

  assign o_alloc_grant = grant_c;
  assign o_free_count  = count;
  assign o_empty       = empty;
  assign o_err         = err;

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Scoreboard bench: a queue-based free-list model predicts each cycle's offer
// and registered state; a negedge monitor compares against the DUT.
module tb_phys_reg_free_list;
  import phys_reg_free_list_pkg::*;

  typedef struct {
    bit grant;
    bit r0;
    bit r1;
    int p0;
    int p1;
    int count;
    bit empty;
    bit err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alloc_req  [0:WIDTH-1];
  p_reg_t      alloc_preg [0:WIDTH-1];
  logic        alloc_grant;
  logic        free_en    [0:WIDTH-1];
  p_reg_t      free_preg  [0:WIDTH-1];
  free_count_t free_count;
  logic        empty;
  logic        err;

  int   mq[$];
  bit   merr;
  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  phys_reg_free_list dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_alloc_req   (alloc_req),
    .o_alloc_preg  (alloc_preg),
    .o_alloc_grant (alloc_grant),
    .i_free_en     (free_en),
    .i_free_preg   (free_preg),
    .o_free_count  (free_count),
    .o_empty       (empty),
    .o_err         (err)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    mq.delete();
    for (int k = NUM_AREGS; k < NUM_PREGS; k++) mq.push_back(k);
    merr = 1'b0;
  endfunction

  function automatic void model_free(input bit en, input int p);
    if (en && p != 0) begin
      if (mq.size() < NUM_PREGS - 1) mq.push_back(p);
      else merr = 1'b1;
    end
  endfunction

  function automatic void check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endfunction

  // One clock of stimulus: predict the cycle, queue the prediction, commit the model.
  task automatic cycle(input bit r0, input bit r1, input bit f0, input int p0,
                       input bit f1, input int p1, input bit rs);
    exp_t e;
    int   nreq;
    @(posedge clk);
    #1;
    rst          = rs;
    alloc_req[0] = r0;
    alloc_req[1] = r1;
    free_en[0]   = f0;
    free_en[1]   = f1;
    free_preg[0] = p_reg_t'(p0);
    free_preg[1] = p_reg_t'(p1);
    nreq    = int'(r0) + int'(r1);
    e.r0    = r0;
    e.r1    = r1;
    e.count = mq.size();
    e.empty = (mq.size() == 0);
    e.err   = merr;
    e.grant = !rs && (mq.size() >= nreq);
    e.p0    = 0;
    e.p1    = 0;
    if (e.grant && r0) e.p0 = mq[0];
    if (e.grant && r1) e.p1 = r0 ? mq[1] : mq[0];
    exp_q.push_back(e);
    if (rs) begin
      model_reset();
    end else begin
      if (e.grant) for (int i = 0; i < nreq; i++) void'(mq.pop_front());
      model_free(f0, p0);
      model_free(f1, p1);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("grant", int'(alloc_grant), int'(e.grant));
      if (e.grant && e.r0) check("preg0", int'(alloc_preg[0]), e.p0);
      if (e.grant && e.r1) check("preg1", int'(alloc_preg[1]), e.p1);
      check("count", int'(free_count), e.count);
      check("empty", int'(empty), int'(e.empty));
      check("err",   int'(err),   int'(e.err));
    end
  end

  initial begin
    alloc_req[0] = 0; alloc_req[1] = 0;
    free_en[0]   = 0; free_en[1]   = 0;
    free_preg[0] = '0; free_preg[1] = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    model_reset();

    // single lane-0 allocation from reset state
    cycle(1, 0, 0, 0, 0, 0, 0);
    idle(1);
    cycle(0, 0, 0, 0, 0, 0, 1);

    // drain with dual requests, then stall on empty
    for (int i = 0; i < 16; i++) cycle(1, 1, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0, 0);
    idle(1);

    // count=1 stall with same-cycle free, then granted pair
    cycle(0, 0, 1, 20, 0, 0, 0);
    cycle(1, 1, 1, 5, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0, 0);
    idle(1);

    // simultaneous alloc/free at 32, FIFO order of returned pregs
    cycle(0, 0, 0, 0, 0, 0, 1);
    cycle(1, 1, 1, 7, 1, 9, 0);
    for (int i = 0; i < 16; i++) cycle(1, 1, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0, 0);

    // p0 release is ignored
    cycle(0, 0, 1, 12, 1, 0, 0);
    cycle(1, 0, 0, 0, 1, 0, 0);
    idle(1);

    // overflow: partial then full drop, sticky err, reset mid-stream
    cycle(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 15; i++) cycle(0, 0, 1, 40 + i, 1, 2 + i, 0);
    cycle(0, 0, 1, 17, 1, 18, 0);
    cycle(0, 0, 1, 19, 1, 21, 0);
    idle(2);
    cycle(1, 1, 1, 3, 1, 4, 1);
    cycle(1, 0, 0, 0, 0, 0, 0);
    idle(1);

    // randomized traffic with occasional reset
    for (int c = 0; c < 1500; c++) begin
      cycle($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, int'($urandom_range(0, 63)),
            $urandom_range(0, 1) == 1, int'($urandom_range(0, 63)),
            $urandom_range(0, 299) == 0);
    end
    idle(2);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
